// File: rtl/freq_monitor_master.sv
// freq_monitor_master: Avalon-MM CSR initiator that periodically reads a
// frequency counter and checks each reading against a min/max window.
module freq_monitor_master #(
    parameter int         POLL_INTERVAL  = 50000,
    parameter int         READ_LATENCY   = 1,
    parameter logic [3:0] FREQ_ADDR      = 4'd0,
    parameter int         SETTLE_SAMPLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] min_count,
    input  logic [31:0] max_count,
    input  logic        clear_sticky,
    output logic [3:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        sample_valid,
    output logic [31:0] sample_value,
    output logic        too_low,
    output logic        too_high,
    output logic        fail_sticky,
    output logic        overrun_sticky,
    output logic [15:0] sample_count
);
    localparam int            CW       = $clog2(POLL_INTERVAL);
    localparam logic [CW-1:0] LAST     = CW'(POLL_INTERVAL - 1);
    localparam logic [1:0]    LAT_N    = 2'(READ_LATENCY);
    localparam logic [7:0]    SETTLE_N = 8'(SETTLE_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_LAT,
        S_EVAL
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] interval;
    logic [1:0]    lat_cnt;
    logic [7:0]    settle;
    logic [31:0]   data;
    logic          pending;
    logic          abort;
    logic          enable_q;
    logic          tick;
    logic          accept;
    logic          capture;
    logic          eval_keep;
    logic          eval_drop;
    logic          low_now;
    logic          high_now;
    logic          fail_set;
    logic          over_set;

    assign tick     = enable && (interval == LAST);
    assign accept   = (state == S_READ) && !m_waitrequest;
    assign capture  = (accept && (READ_LATENCY == 0))
                   || ((state == S_LAT) && (lat_cnt == LAT_N));
    assign low_now  = data < min_count;
    assign high_now = data > max_count;
    assign fail_set = eval_keep && (low_now || high_now);
    assign over_set = tick && ((state != S_WAIT) || pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        m_read    = 1'b0;
        m_address = 4'd0;
        eval_keep = 1'b0;
        eval_drop = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) state_nx = S_IDLE;
                else if (pending || tick) state_nx = S_READ;
            end
            S_READ: begin
                m_read    = 1'b1;
                m_address = FREQ_ADDR;
                if (!m_waitrequest)
                    state_nx = (READ_LATENCY == 0) ? S_EVAL : S_LAT;
            end
            S_LAT: begin
                if (lat_cnt == LAT_N) state_nx = S_EVAL;
            end
            S_EVAL: begin
                // A read that lost enable mid-flight is thrown away whole.
                if (!abort) begin
                    if (settle != 8'd0) eval_drop = 1'b1;
                    else eval_keep = 1'b1;
                end
                state_nx = (enable && !abort) ? S_WAIT : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            interval <= '0;
            pending  <= 1'b0;
            enable_q <= 1'b0;
            settle   <= 8'd0;
            lat_cnt  <= 2'd0;
            data     <= 32'd0;
            abort    <= 1'b0;
        end else begin
            enable_q <= enable;
            if (!enable || tick) interval <= '0;
            else interval <= interval + 1'b1;
            if ((state == S_WAIT) && (state_nx != S_WAIT)) pending <= 1'b0;
            else if (tick && (state == S_WAIT)) pending <= 1'b1;
            if (enable && !enable_q) settle <= SETTLE_N;
            else if (eval_drop) settle <= settle - 1'b1;
            if (accept) lat_cnt <= 2'd1;
            else if (state == S_LAT) lat_cnt <= lat_cnt + 1'b1;
            if (capture) data <= m_readdata;
            if ((state == S_IDLE) || (state == S_WAIT)) abort <= 1'b0;
            else if (((state == S_READ) || (state == S_LAT)) && !enable)
                abort <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_valid   <= 1'b0;
            sample_value   <= 32'd0;
            too_low        <= 1'b0;
            too_high       <= 1'b0;
            fail_sticky    <= 1'b0;
            overrun_sticky <= 1'b0;
            sample_count   <= 16'd0;
        end else begin
            sample_valid <= eval_keep;
            if (eval_keep) begin
                sample_value <= data;
                too_low      <= low_now;
                too_high     <= high_now;
                if (sample_count != 16'hFFFF)
                    sample_count <= sample_count + 1'b1;
            end
            // New events win over a coincident clear.
            fail_sticky    <= fail_set || (fail_sticky && !clear_sticky);
            overrun_sticky <= over_set || (overrun_sticky && !clear_sticky);
        end
    end
endmodule

// File: tb/tb_freq_monitor_master.sv
// Scoreboard bench: three monitors at read latency 1, 0 and 3 share clock,
// reset, window bounds and clear; only one is enabled at a time.
`timescale 1ns/1ps
module tb_freq_monitor_master;
    localparam int         PI = 20;
    localparam logic [3:0] FA = 4'hA;

    typedef struct {
        int          id;
        logic [31:0] value;
        logic        lo;
        logic        hi;
        logic        fail;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [31:0] v;
        logic        lo;
        logic        hi;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] min_count = 32'd0;
    logic [31:0] max_count = 32'd0;
    logic        clear_sticky = 1'b0;
    logic [2:0]  en = 3'b000;
    logic [2:0]  ws = 3'b000;
    logic [2:0]  mrd, sv, lo, hi, fs, os;
    logic [3:0]  addr [3];
    logic [31:0] rdata [3];
    logic [31:0] sval [3];
    logic [31:0] val [3];
    logic [15:0] scnt [3];
    logic [15:0] m_cnt [3];
    logic        m_fail [3];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          sv_cyc = 0;
    exp_t        sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RL = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [1:0] lat = 2'd0;
        logic       hit;
        // Valid word only on the exact latency cycle, garbage otherwise.
        assign hit = (RL == 0) ? (mrd[g] && !ws[g]) : (lat == 2'(RL));
        assign rdata[g] = hit ? val[g] : (32'hBAD0_0000 ^ 32'(cyc));
        always @(posedge clk) begin
            if (mrd[g] && !ws[g]) lat <= (RL == 0) ? 2'd0 : 2'd1;
            else if (lat != 2'd0 && lat < 2'(RL)) lat <= lat + 2'd1;
            else lat <= 2'd0;
        end
        freq_monitor_master #(
            .POLL_INTERVAL (PI),
            .READ_LATENCY  (RL),
            .FREQ_ADDR     (FA),
            .SETTLE_SAMPLES(2)
        ) dut (
            .clk           (clk),
            .reset         (reset),
            .enable        (en[g]),
            .min_count     (min_count),
            .max_count     (max_count),
            .clear_sticky  (clear_sticky),
            .m_address     (addr[g]),
            .m_read        (mrd[g]),
            .m_readdata    (rdata[g]),
            .m_waitrequest (ws[g]),
            .sample_valid  (sv[g]),
            .sample_value  (sval[g]),
            .too_low       (lo[g]),
            .too_high      (hi[g]),
            .fail_sticky   (fs[g]),
            .overrun_sticky(os[g]),
            .sample_count  (scnt[g])
        );
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (sv[g]) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_sample dut%0d: got value=%0d cnt=%0d, want no sample",
                             g, sval[g], scnt[g]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    sv_cyc = cyc;
                    if (e.id != g || sval[g] != e.value || lo[g] != e.lo || hi[g] != e.hi
                        || fs[g] != e.fail || scnt[g] != e.cnt) begin
                        fails++;
                        $display("FAIL sample dut%0d: got value=%0d lo=%0b hi=%0b fail=%0b cnt=%0d, want dut%0d value=%0d lo=%0b hi=%0b fail=%0b cnt=%0d",
                                 g, sval[g], lo[g], hi[g], fs[g], scnt[g],
                                 e.id, e.value, e.lo, e.hi, e.fail, e.cnt);
                    end
                end
            end
        end
    end

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic logic zero(input int g);
        return !mrd[g] && addr[g] == 4'd0 && !sv[g] && sval[g] == 32'd0 && !lo[g]
            && !hi[g] && !fs[g] && !os[g] && scnt[g] == 16'd0;
    endfunction

    task automatic push_exp(input int g, input logic [31:0] v, input logic l, input logic h);
        exp_t e;
        m_cnt[g]  = m_cnt[g] + 16'd1;
        m_fail[g] = m_fail[g] | l | h;
        e = '{g, v, l, h, m_fail[g], m_cnt[g]};
        sb.push_back(e);
    endtask

    task automatic wait_accept(input int g, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mrd[g] && !ws[g]) && n < 4 * PI);
        at = cyc;
        if (!(mrd[g] && !ws[g])) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout dut%0d: got no accepted read in %0d cycles", g, n);
        end
    endtask

    task automatic wait_mread(input int g, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mrd[g] && n < 4 * PI);
        at = cyc;
        if (!mrd[g]) begin
            tests++;
            fails++;
            $display("FAIL mread_timeout dut%0d: got no read request in %0d cycles", g, n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3 * PI) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d samples outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_sticky = 1'b1;
        for (int g = 0; g < 3; g++) m_fail[g] = 1'b0;
        @(negedge clk);
        clear_sticky = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   a1, a2, a3, r, acc, bad;
        vec_t vecs [4];
        vecs[0] = '{32'd49000, 1'b0, 1'b0};
        vecs[1] = '{32'd51000, 1'b0, 1'b0};
        vecs[2] = '{32'd48999, 1'b1, 1'b0};
        vecs[3] = '{32'd51001, 1'b0, 1'b1};
        for (int g = 0; g < 3; g++) begin
            val[g]    = 32'd0;
            m_cnt[g]  = 16'd0;
            m_fail[g] = 1'b0;
        end

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) check_eq("reset_state", 32'(zero(g)), 32'd1);
        reset = 1'b0;

        // Settle discard, spacing and latency at READ_LATENCY=1
        min_count = 32'd49000;
        max_count = 32'd51000;
        val[0] = 32'd50000;
        push_exp(0, 32'd50000, 1'b0, 1'b0);
        en[0] = 1'b1;
        wait_accept(0, a1);
        wait_accept(0, a2);
        wait_accept(0, a3);
        drain();
        check_eq("t1_spacing_12", 32'(a2 - a1), 32'(PI));
        check_eq("t1_spacing_23", 32'(a3 - a2), 32'(PI));
        check_eq("t1_accept_to_valid", 32'(sv_cyc - a3), 32'd3);

        // Inclusive bounds and sticky fail
        for (int i = 0; i < 4; i++) begin
            val[0] = vecs[i].v;
            push_exp(0, vecs[i].v, vecs[i].lo, vecs[i].hi);
            wait_accept(0, a1);
            drain();
        end
        check_eq("t2_fail_set", 32'(fs[0]), 32'd1);
        pulse_clear();
        check_eq("t2_fail_cleared", 32'(fs[0]), 32'd0);

        // Long stall: request held, tick dropped, one read completes
        val[0] = 32'd50000;
        ws[0] = 1'b1;
        push_exp(0, 32'd50000, 1'b0, 1'b0);
        wait_mread(0, r);
        bad = 0;
        for (int i = 0; i < PI + 10; i++) begin
            if (!mrd[0] || addr[0] != FA) bad++;
            @(negedge clk);
        end
        check_eq("t3_stall_unstable_cycles", 32'(bad), 32'd0);
        check_eq("t3_overrun", 32'(os[0]), 32'd1);
        ws[0] = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (mrd[0] && !ws[0]) acc++;
            @(negedge clk);
        end
        check_eq("t3_reads_after_release", 32'(acc), 32'd1);
        drain();
        pulse_clear();
        check_eq("t3_overrun_cleared", 32'(os[0]), 32'd0);

        // Enable drops during a stalled read
        val[0] = 32'd50500;
        ws[0] = 1'b1;
        wait_mread(0, r);
        @(negedge clk);
        en[0] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t4_read_held", 32'(mrd[0]), 32'd1);
        ws[0] = 1'b0;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            if (mrd[0] && !ws[0]) acc++;
            @(negedge clk);
        end
        check_eq("t4_reads_while_disabled", 32'(acc), 32'd1);
        check_eq("t4_idle_no_read", 32'(mrd[0]), 32'd0);
        push_exp(0, 32'd50500, 1'b0, 1'b0);
        en[0] = 1'b1;
        wait_accept(0, a1);
        wait_accept(0, a2);
        wait_accept(0, a3);
        drain();

        // Reset while in LAT
        wait_accept(0, a1);
        @(negedge clk);
        reset = 1'b1;
        en[0] = 1'b0;
        @(negedge clk);
        check_eq("t5_reset_in_lat", 32'(zero(0)), 32'd1);
        reset = 1'b0;
        for (int g = 0; g < 3; g++) begin
            m_cnt[g]  = 16'd0;
            m_fail[g] = 1'b0;
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!zero(0)) bad++;
        end
        check_eq("t5_quiet_after_reset", 32'(bad), 32'd0);

        // READ_LATENCY 0 and 3 capture the exact latency cycle
        min_count = 32'd100;
        max_count = 32'd200;
        for (int g = 1; g < 3; g++) begin
            val[g] = 32'd150;
            push_exp(g, 32'd150, 1'b0, 1'b0);
            en[g] = 1'b1;
            wait_accept(g, a1);
            wait_accept(g, a2);
            wait_accept(g, a3);
            drain();
            check_eq($sformatf("t6_accept_to_valid_dut%0d", g), 32'(sv_cyc - a3),
                     (g == 1) ? 32'd2 : 32'd5);
            val[g] = 32'd250;
            push_exp(g, 32'd250, 1'b0, 1'b1);
            wait_accept(g, a1);
            drain();
            en[g] = 1'b0;
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/freq_monitor_master.md
Name: freq_monitor_master

Overview:
- Avalon-MM CSR initiator that periodically polls a frequency-counter CSR slave.
- Reads the measured count and checks it against a programmable min/max window.
- Reports per-sample results plus sticky fail flags.
- Sits in the board-test system between the frequency-counter slave and the test-control logic, so clock checks run without CPU polling.

Parameters:
- POLL_INTERVAL, 50000, clk cycles between poll requests (1 ms at 50 MHz); minimum 4.
- READ_LATENCY, 1, fixed slave read latency in clk cycles after read acceptance; legal 0..3.
- FREQ_ADDR, 4'd0, CSR word address of the frequency register.
- SETTLE_SAMPLES, 2, results discarded after each enable rising edge (first windows incomplete).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run polling while high
- min_count  in  32  inclusive lower bound
- max_count  in  32  inclusive upper bound
- clear_sticky  in  1  one-cycle pulse; clears fail_sticky and overrun_sticky
- m_address  out  4  CSR address to slave
- m_read  out  1  read request
- m_readdata  in  32  slave read data
- m_waitrequest  in  1  slave stall
- sample_valid  out  1  one-cycle pulse when a new evaluated sample is presented
- sample_value  out  32  last evaluated count
- too_low  out  1  last sample < min_count
- too_high  out  1  last sample > max_count
- fail_sticky  out  1  any evaluated sample out of range since clear/reset
- overrun_sticky  out  1  a poll tick was dropped
- sample_count  out  16  evaluated samples since reset; saturates at 16'hFFFF

Behaviour:
- Reset (synchronous, sampled on clk rise) zeroes every output, the interval counter, the settle counter, and the pending tick, and forces state IDLE. m_address resets to 0. Reset wins over all other inputs, including mid-transaction; the slave is required to tolerate an abandoned read.
- Interval counter: runs 0..POLL_INTERVAL-1 while enable is high and wraps to 0. At wrap, a tick is generated. It holds at 0 while enable is low.
- Pending tick: one-deep. A tick sets it; leaving WAIT clears it.
  - A tick arriving while pending is already set (or state is not WAIT) sets overrun_sticky and is dropped.
- Settle counter: loaded with SETTLE_SAMPLES on the enable rising edge. It decrements on each completed read until 0.
- FSM states:
  - IDLE: m_read=0. Enter WAIT when enable=1.
  - WAIT: if enable=0, go to IDLE. If a tick is pending, go to READ.
  - READ: m_read=1 and m_address=FREQ_ADDR, held stable until a cycle with m_waitrequest=0. That cycle is acceptance.
    - READ_LATENCY=0: data is captured in the acceptance cycle, then go to EVAL.
    - Otherwise go to LAT.
  - LAT: counts READ_LATENCY cycles; m_readdata is captured on the READ_LATENCY-th clk after acceptance. Then go to EVAL.
  - EVAL (one cycle):
    - If settle>0: decrement it, discard the data, no sample_valid.
    - Else: update sample_value, too_low and too_high, and sample_count. Pulse sample_valid the next cycle (registered outputs valid together with the pulse). OR (too_low|too_high) into fail_sticky.
    - Then go to WAIT if enable=1, else IDLE.
- enable dropping during READ/LAT: the transaction completes (m_read is never withdrawn before acceptance). The result is discarded, with no sample_valid and no flag update, then go to IDLE.
- Compare rules: 32-bit unsigned, inclusive bounds.
  - value==min_count and value==max_count are both in range.
  - If min_count>max_count, both flags may assert; this is legal and counts as a fail.
  - min/max are sampled in EVAL, so a change takes effect on the next sample.
- clear_sticky coincident with a new fail or overrun event: set wins.
- Latency: tick to m_read = 1 cycle (no stall). Acceptance to sample_valid = READ_LATENCY+2 cycles.

Test Plan:
1. Responder with READ_LATENCY=1, no stall, returns 50000; min=49000, max=51000, enable high → first 2 reads produce no sample_valid. The 3rd read gives sample_valid, sample_value=50000, too_low=0, too_high=0, sample_count=1. Reads are spaced exactly POLL_INTERVAL cycles apart.
2. Boundary values: returns 49000, then 51000, then 48999, then 51001 → first two in range. Third gives too_low=1; fourth gives too_high=1. fail_sticky set from the third sample. clear_sticky then clears it.
3. m_waitrequest held high for POLL_INTERVAL+10 cycles → m_read and m_address stay stable throughout. overrun_sticky=1. Exactly one read completes after the stall releases.
4. Deassert enable one cycle after m_read rises, with 5-cycle stall → read completes and no sample_valid. FSM enters IDLE. Re-enable → two settle reads are discarded again.
5. Assert reset while in LAT → next cycle all outputs are 0 and m_read=0. Later m_readdata activity has no effect.
6. Sweep READ_LATENCY=0 and 3, with the responder driving the value only on the exact latency cycle and garbage otherwise → sample_value matches the correct word.
